// File: rtl/win_pkg.sv
// Shared types for the 3x3 window controller.
// State encoding and the window-row width.
package win_pkg;

  localparam int ROW_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/win3x3_ctrl.sv
// Sequencer for an external 3-row line buffer producing 3x3 windows.
// Define WIN3X3_CTRL_ERR_EN to build the sticky frame_err logic.
module win3x3_ctrl
  import win_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int IMG_ROWS   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sb_clken,
  output logic [DATA_WIDTH-1:0] sb_shiftin,
  output logic                  win_valid,
  output logic [ROW_W-1:0]      win_row,
  output logic [ADDR_WIDTH-1:0] win_col,
  output logic                  eof,
  output logic                  frame_err
);

  state_e                state_q;
  logic [ROW_W-1:0]      row_q;
  logic [ADDR_WIDTH-1:0] col_q;
  logic                  sof;
  logic                  act_st;
  logic                  col_last;
  logic                  win_hit;

  assign sof      = in_valid && in_sof;
  assign act_st   = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign col_last = (col_q == '1);
  assign win_hit  = (row_q >= ROW_W'(2)) &&
                    (col_q >= ADDR_WIDTH'(2));

  assign sb_clken   = in_valid &&
                      (act_st || (state_q == ST_IDLE && in_sof));
  assign sb_shiftin = in_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      eof       <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      eof       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sof) begin
            state_q <= ST_FILL;
            row_q   <= '0;
            col_q   <= ADDR_WIDTH'(1);
          end
        end
        ST_FILL, ST_RUN: begin
          if (sof) begin
            // A new sof always wins: the sof pixel is (0,0)
            state_q <= ST_FILL;
            row_q   <= '0;
            col_q   <= ADDR_WIDTH'(1);
          end else if (in_valid) begin
            win_valid <= win_hit;
            if (win_hit) begin
              win_row <= row_q - 1'b1;
              win_col <= col_q - 1'b1;
            end
            col_q <= col_q + 1'b1;
            if (col_last) begin
              row_q <= row_q + 1'b1;
              if (state_q == ST_FILL && row_q == ROW_W'(1))
                state_q <= ST_RUN;
              if (state_q == ST_RUN &&
                  row_q == ROW_W'(IMG_ROWS - 1)) begin
                state_q <= ST_DONE;
                row_q   <= '0;
                eof     <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef WIN3X3_CTRL_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((act_st && sof) ||
                 (state_q == ST_DONE && in_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign frame_err = err_q;
`else
  assign frame_err = 1'b0;
`endif

endmodule
